// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver: 16x-oversampled UART receive path.
// Frame = 1 start bit, DBIT data bits (LSB first), 1 stop bit.
// The start bit is confirmed at mid-bit. Each data bit is sampled at its centre.
// The assembled word is presented with a one-clock rx_done pulse.
// Optional feature macro: RX_PARITY_EN. It adds an even-parity bit after the
// data bits and a parity_err output.
module uart_receiver #(
    parameter int DBIT    = 8,   // data bits per frame (5..8)
    parameter int SB_TICK = 16   // oversampling ticks spent in the stop bit
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
`ifdef RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t            state, state_next;
    logic [3:0]        s_reg, s_next;     // tick count within the current bit
    logic [2:0]        n_reg, n_next;     // index of the data bit being received
    logic [DBIT-1:0]   b_reg, b_next;     // shift register for the incoming word
    logic [DBIT-1:0]   d_out_next;
    logic              done_next;
    logic              ferr_next;
    logic              rx_meta, rx_s;
`ifdef RX_PARITY_EN
    logic              par_bad_reg, par_bad_next;
    logic              perr_next;
`endif

    // Bring the asynchronous rx pin into the clk domain.
    // Both flops reset high so a reset does not look like a start bit.
    // NOTE: sequential state always uses non-blocking assignments.
    // The second flop then samples the first flop's old value, not the value
    // just written in this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs.
    // NOTE: every register here is a plain flop and gets an explicit reset value.
    // A reset in mid-frame therefore discards the partial word with no
    // further handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad_reg <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            d_out     <= d_out_next;
            rx_done   <= done_next;
            frame_err <= ferr_next;
`ifdef RX_PARITY_EN
            par_bad_reg <= par_bad_next;
            parity_err  <= perr_next;
`endif
        end
    end

    // Next-state logic.
    // Counting advances only on s_tick, except start-edge detection in IDLE.
    always_comb begin
        // NOTE: every output of this block is given a default first.
        // A path that forgets to assign a signal then holds the registered
        // value instead of inferring a latch.
        state_next = state;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        d_out_next = d_out;
        done_next  = 1'b0;
        ferr_next  = frame_err;
`ifdef RX_PARITY_EN
        par_bad_next = par_bad_reg;
        perr_next    = parity_err;
`endif

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_reg == 4'd7) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // The line went high again before mid-bit.
                            // Treat it as a glitch and leave the outputs alone.
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == 3'(DBIT - 1)) begin
`ifdef RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

`ifdef RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        // Even parity: the parity bit must equal the XOR of the data bits.
                        par_bad_next = rx_s ^ (^b_reg);
                        s_next       = '0;
                        state_next   = STOP;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
`endif

            STOP: begin
                if (s_tick) begin
                    if (s_reg == 4'(SB_TICK - 1)) begin
                        d_out_next = b_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef RX_PARITY_EN
                        perr_next  = par_bad_reg;
`endif
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// tb_uart_receiver: directed checks of the UART receiver.
// The clock period is 10 ns and s_tick fires every 4 clocks.
// One bit period is therefore 16 ticks = 64 clocks.
module tb_uart_receiver;

`ifdef RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
`ifdef RX_PARITY_EN
    logic       parity_err;
`endif

    int         tests    = 0;
    int         fails    = 0;
    int         done_cnt = 0;
    time        done_t[$];
    logic [7:0] done_data[$];

    uart_receiver #(.DBIT(8), .SB_TICK(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tick    (s_tick),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Baud tick: one clock wide, every fourth clock.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Record every rx_done pulse: its time and the word presented with it.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            done_t.push_back($time);
            done_data.push_back(d_out);
        end
    end

    // Watchdog: stimulus is fixed-length, so this fires only on a hang.
    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame, starting at the current negedge.
    // The stop bit is driven for 48 clocks and the line then returns high.
    // The stop sample falls well inside those 48 clocks.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, output time t0);
        t0 = $time;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (64) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        rx = par_bit;
        repeat (64) @(negedge clk);
`else
        if (par_bit) begin end
`endif
        rx = stop_bit;
        repeat (48) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        time t0, t1;
        int  n0;
        int  lat;

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_d_out", d_out, 8'h00);
        check("reset_rx_done", rx_done, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA5 with a good stop bit
        n0 = done_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        check("a5_pulses", done_cnt - n0, 1);
        check("a5_d_out", d_out, 8'hA5);
        check("a5_frame_err", frame_err, 1'b0);
        lat = (done_cnt > n0) ? int'((done_t[n0] - t0) / 10) : 0;
        check("a5_latency_window", (lat >= 607 + 64*PBITS) && (lat <= 612 + 64*PBITS), 1'b1);
        repeat (64) @(negedge clk);

        // Glitch: rx low for 5 ticks only
        n0 = done_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_pulse", done_cnt - n0, 0);
        check("glitch_d_out_held", d_out, 8'hA5);

        // 0x3C with a bad stop bit, then a good frame
        n0 = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        check("bad_stop_pulses", done_cnt - n0, 1);
        check("bad_stop_d_out", d_out, 8'h3C);
        check("bad_stop_frame_err", frame_err, 1'b1);
        repeat (200) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        check("good_stop_d_out", d_out, 8'h3C);
        check("good_stop_frame_err", frame_err, 1'b0);
        repeat (64) @(negedge clk);

        // Back-to-back 0x00 then 0xFF with no idle gap
        n0 = done_cnt;
        send_frame(8'h00, 1'b1, 1'b0, t0);
        send_frame(8'hFF, 1'b1, 1'b1, t1);
        check("b2b_pulses", done_cnt - n0, 2);
        check("b2b_first_word", (done_cnt >= n0 + 2) ? done_data[n0] : 8'hxx, 8'h00);
        check("b2b_second_word", (done_cnt >= n0 + 2) ? done_data[n0+1] : 8'hxx, 8'hFF);
        check("b2b_pulse_spacing_ns",
              (done_cnt >= n0 + 2) ? 64'(done_t[n0+1] - done_t[n0]) : 64'd0,
              64'(6400 + 640*PBITS));
        check("b2b_frame_err", frame_err, 1'b0);
        repeat (64) @(negedge clk);

        // Reset asserted in bit 4 of 0x55
        n0 = done_cnt;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;  // 0x55 bits 0..3 = 1,0,1,0
            repeat (64) @(negedge clk);
        end
        rx = 1'b1;                     // bit 4 of 0x55
        repeat (32) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_d_out", d_out, 8'h00);
        check("rst_mid_frame_err", frame_err, 1'b0);
        check("rst_mid_rx_done", rx_done, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("rst_abort_no_pulse", done_cnt - n0, 0);
        send_frame(8'h81, 1'b1, 1'b0, t0);
        check("after_rst_pulses", done_cnt - n0, 1);
        check("after_rst_d_out", d_out, 8'h81);
        check("after_rst_frame_err", frame_err, 1'b0);
        repeat (64) @(negedge clk);

`ifdef RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1, t0);
        check("par_ok_d_out", d_out, 8'h07);
        check("par_ok_parity_err", parity_err, 1'b0);
        repeat (64) @(negedge clk);
        n0 = done_cnt;
        send_frame(8'h07, 1'b1, 1'b0, t0);
        check("par_bad_pulses", done_cnt - n0, 1);
        check("par_bad_d_out", d_out, 8'h07);
        check("par_bad_parity_err", parity_err, 1'b1);
        repeat (64) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
